// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory with a valid/ready request/response handshake.
// A fetch is read synchronously in its accept cycle. The response then
// appears LATENCY+1 cycles later and is held until the consumer takes it.
// A separate byte-enabled write port loads the program into memory.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o fetch request handshake
//   req_addr_i              byte address of the instruction
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_inst_o, rsp_err_o   fetched word, or NOP with a fault flag
//   flush_i                 drops any outstanding fetch
//   wr_en_i, wr_addr_i,
//   wr_data_i, wr_be_i      program-load write port
module instr_fetch_mem #(
  parameter int MEM_SIZE   = 1024,
  parameter int INST_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [INST_WIDTH-1:0]   rsp_inst_o,
  output logic                    rsp_err_o,
  input  logic                    flush_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [INST_WIDTH-1:0]   wr_data_i,
  input  logic [INST_WIDTH/8-1:0] wr_be_i
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam int BE_W  = INST_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] WORDS = ADDR_WIDTH'(MEM_SIZE);
  localparam logic [INST_WIDTH-1:0] NOP   = INST_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [INST_WIDTH-1:0]   mem [MEM_SIZE];

  logic                    accept;
  logic                    fetch_err;
  logic                    wr_ok;
  logic [IDX_W-1:0]        rd_idx;
  logic [IDX_W-1:0]        wr_idx;

  assign fetch_err = (req_addr_i[1:0] != 2'b00) || ((req_addr_i >> 2) >= WORDS);
  assign wr_ok     = (wr_addr_i[1:0] == 2'b00) && ((wr_addr_i >> 2) < WORDS);
  assign rd_idx    = req_addr_i[IDX_W+1:2];
  assign wr_idx    = wr_addr_i[IDX_W+1:2];

  always_comb begin
    req_ready_o = 1'b0;
    if (!rst_i && !flush_i) begin
      case (state)
        S_IDLE:  req_ready_o = 1'b1;
        S_RESP:  req_ready_o = rsp_ready_i;
        default: req_ready_o = 1'b0;
      endcase
    end
  end

  assign accept = req_valid_i && req_ready_o;

  // Program-load port; the fetch path samples the old word on a same-cycle hit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && wr_ok) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) mem[wr_idx][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rsp_valid_o <= 1'b0;
      rsp_inst_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else if (flush_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rsp_valid_o <= 1'b0;
    end else if (accept) begin
      // accept only happens in IDLE or in RESP while the response is taken,
      // so both the fresh start and the back-to-back restart share this path
      rsp_inst_o <= fetch_err ? NOP : mem[rd_idx];
      rsp_err_o  <= fetch_err;
      if (LATENCY == 0) begin
        state       <= S_RESP;
        rsp_valid_o <= 1'b1;
      end else begin
        state       <= S_WAIT;
        cnt         <= 3'(LATENCY);
        rsp_valid_o <= 1'b0;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 3'd1) begin
            state       <= S_RESP;
            cnt         <= '0;
            rsp_valid_o <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state       <= S_IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: three instances (LATENCY 0, 3, 2) share one
// stimulus stream. A timestamp-based reference model predicts handshake and
// response values for every instance on every cycle; directed sequences and
// a vector table add fixed expectations for the corner cases.
module tb_instr_fetch_mem;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic        rdy  [N];
  logic        vld  [N];
  logic [31:0] inst [N];
  logic        err  [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_fetch_mem #(
      .MEM_SIZE  (1024),
      .INST_WIDTH(32),
      .ADDR_WIDTH(32),
      .LATENCY   (g == 0 ? 0 : (g == 1 ? 3 : 2))
    ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_valid_i(req_valid),
      .req_ready_o(rdy[g]),
      .req_addr_i (req_addr),
      .rsp_valid_o(vld[g]),
      .rsp_ready_i(rsp_ready),
      .rsp_inst_o (inst[g]),
      .rsp_err_o  (err[g]),
      .flush_i    (flush),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .wr_be_i    (wr_be)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] mref [1024];
  logic        busy [N] = '{1'b0, 1'b0, 1'b0};
  int          due  [N];
  logic [31:0] edata[N];
  logic        eerr [N];
  int          cyc = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
  endfunction

  function automatic logic m_shown(input int i);
    return busy[i] && (cyc >= due[i]);
  endfunction

  function automatic logic m_ready(input int i);
    return !rst && !flush && (!busy[i] || (m_shown(i) && rsp_ready));
  endfunction

  function automatic logic [31:0] init_word(input int w);
    if (w == 0) return 32'h0050_0093;
    if (w == 3) return 32'h0000_0000;
    return {8'hA5, 8'(w), 8'h5A, 8'(~w)};
  endfunction

  always @(posedge clk or posedge rst) begin : mdl
    logic acc;
    if (rst) begin
      for (int i = 0; i < N; i++) busy[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        acc = m_ready(i) && req_valid;
        if (flush) begin
          busy[i] = 1'b0;
        end else begin
          if (m_shown(i) && rsp_ready) busy[i] = 1'b0;
          if (acc) begin
            busy[i]  = 1'b1;
            due[i]   = cyc + 1 + lat_of(i);
            eerr[i]  = (req_addr[1:0] != 2'b00) || (req_addr >= 32'h1000);
            edata[i] = eerr[i] ? 32'h0000_0013 : mref[req_addr[11:2]];
          end
        end
      end
      if (wr_en && wr_addr[1:0] == 2'b00 && wr_addr < 32'h1000) begin
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) mref[wr_addr[11:2]][b*8 +: 8] = wr_data[b*8 +: 8];
      end
      cyc = cyc + 1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        chk($sformatf("rst_ready%0d", i), {31'b0, rdy[i]}, 32'd0);
        chk($sformatf("rst_valid%0d", i), {31'b0, vld[i]}, 32'd0);
        chk($sformatf("rst_inst%0d", i), inst[i], 32'd0);
        chk($sformatf("rst_err%0d", i), {31'b0, err[i]}, 32'd0);
      end else begin
        chk($sformatf("ready%0d@%0d", i, cyc), {31'b0, rdy[i]}, {31'b0, m_ready(i)});
        chk($sformatf("valid%0d@%0d", i, cyc), {31'b0, vld[i]}, {31'b0, m_shown(i)});
        if (m_shown(i)) begin
          chk($sformatf("inst%0d@%0d", i, cyc), inst[i], edata[i]);
          chk($sformatf("err%0d@%0d", i, cyc), {31'b0, err[i]}, {31'b0, eerr[i]});
        end
      end
    end
  endtask

  // inputs are set just after a negedge; outputs are checked before the next one
  task automatic cyc_end();
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    flush     = 1'b0;
    wr_en     = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic quiesce();
    idle();
    flush = 1'b1;
    cyc_end();
    idle();
    cyc_end();
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t vt [8];

  initial begin
    vt[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
    vt[1] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
    vt[2] = '{32'h0000_0004, init_word(1),  1'b0};
    vt[3] = '{32'h0000_1000, 32'h0000_0013, 1'b1};
    vt[4] = '{32'h0000_0008, init_word(2),  1'b0};
    vt[5] = '{32'h0000_0003, 32'h0000_0013, 1'b1};
    vt[6] = '{32'hFFFF_FFFC, 32'h0000_0013, 1'b1};
    vt[7] = '{32'h0000_000C, 32'h0000_0000, 1'b0};

    rst = 1'b1;
    req_addr = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = '0;
    idle();
    @(negedge clk);
    cyc_end();
    cyc_end();

    // reset release: ready comes up on all instances
    rst = 1'b0;
    #1;
    for (int i = 0; i < N; i++) chk($sformatf("release_ready%0d", i), {31'b0, rdy[i]}, 32'd1);
    cyc_end();

    // program load
    for (int w = 0; w < 64; w++) begin
      wr_en = 1'b1; wr_addr = 32'(w * 4); wr_data = init_word(w); wr_be = 4'hF;
      cyc_end();
    end
    idle();
    cyc_end();

    // back-to-back vector table on the LATENCY=0 instance
    quiesce();
    for (int k = 0; k < 8; k++) begin
      req_valid = 1'b1; req_addr = vt[k].addr;
      #1 chk($sformatf("tbl_ready%0d", k), {31'b0, rdy[0]}, 32'd1);
      cyc_end();
      chk($sformatf("tbl_valid%0d", k), {31'b0, vld[0]}, 32'd1);
      chk($sformatf("tbl_inst%0d", k), inst[0], vt[k].exp_inst);
      chk($sformatf("tbl_err%0d", k), {31'b0, err[0]}, {31'b0, vt[k].exp_err});
    end
    idle();
    cyc_end();

    // LATENCY=3: valid exactly 4 cycles after accept, not ready in WAIT
    quiesce();
    req_valid = 1'b1; req_addr = 32'h4;
    #1 chk("lat3_accept", {31'b0, rdy[1]}, 32'd1);
    cyc_end();
    req_addr = 32'h8;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("lat3_valid_c%0d", k), {31'b0, vld[1]}, 32'd0);
      chk($sformatf("lat3_ready_c%0d", k), {31'b0, rdy[1]}, 32'd0);
      cyc_end();
    end
    chk("lat3_valid_c4", {31'b0, vld[1]}, 32'd1);
    chk("lat3_inst_c4", inst[1], init_word(1));
    chk("lat3_err_c4", {31'b0, err[1]}, 32'd0);
    idle();
    cyc_end();

    // backpressure hold, then accept 0x8 in the release cycle
    quiesce();
    req_valid = 1'b1; req_addr = 32'h0;
    cyc_end();
    rsp_ready = 1'b0; req_addr = 32'h8;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold_valid%0d", k), {31'b0, vld[0]}, 32'd1);
      chk($sformatf("hold_inst%0d", k), inst[0], 32'h0050_0093);
      chk($sformatf("hold_err%0d", k), {31'b0, err[0]}, 32'd0);
      chk($sformatf("hold_ready%0d", k), {31'b0, rdy[0]}, 32'd0);
      cyc_end();
    end
    rsp_ready = 1'b1;
    #1 chk("release_accept", {31'b0, rdy[0]}, 32'd1);
    cyc_end();
    req_valid = 1'b0;
    chk("after_hold_inst", inst[0], init_word(2));
    chk("after_hold_valid", {31'b0, vld[0]}, 32'd1);
    cyc_end();

    // LATENCY=2 flush one cycle after accept
    quiesce();
    req_valid = 1'b1; req_addr = 32'h0;
    #1 chk("flush_accept", {31'b0, rdy[2]}, 32'd1);
    cyc_end();
    flush = 1'b1; req_addr = 32'h4;
    #1 chk("flush_ready", {31'b0, rdy[2]}, 32'd0);
    cyc_end();
    idle();
    #1 chk("post_flush_ready", {31'b0, rdy[2]}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("post_flush_valid%0d", k), {31'b0, vld[2]}, 32'd0);
      cyc_end();
    end

    // partial write, read-before-write, ignored bad writes
    quiesce();
    wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'hDEAD_BEEF; wr_be = 4'b0011;
    cyc_end();
    wr_data = 32'h1234_5678; wr_be = 4'hF;
    req_valid = 1'b1; req_addr = 32'hC;
    cyc_end();
    chk("rbw_old_word", inst[0], 32'h0000_BEEF);
    wr_addr = 32'hD; wr_data = 32'hFFFF_FFFF;
    cyc_end();
    chk("new_word", inst[0], 32'h1234_5678);
    wr_addr = 32'h1000;
    cyc_end();
    chk("misaligned_wr_ignored", inst[0], 32'h1234_5678);
    wr_en = 1'b0; req_addr = 32'h0;
    cyc_end();
    chk("range_wr_ignored", inst[0], 32'h0050_0093);
    idle();
    cyc_end();

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int unsigned wd;
      req_valid = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 9))
        0:       req_addr = 32'($urandom_range(0, 255));
        1:       req_addr = $urandom | 32'h0000_1000;
        default: req_addr = 32'($urandom_range(0, 63)) * 4;
      endcase
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 15) == 0);
      wr_en     = ($urandom_range(0, 3) == 0);
      wd = $urandom_range(0, 63);
      case ($urandom_range(0, 7))
        0:       wr_addr = wd * 4 + $urandom_range(1, 3);
        1:       wr_addr = 32'h0000_1000 | (wd * 4);
        default: wr_addr = wd * 4;
      endcase
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      cyc_end();
    end
    idle();
    cyc_end();

    // reset in the middle of a LATENCY=3 fetch
    quiesce();
    req_valid = 1'b1; req_addr = 32'h4;
    cyc_end();
    req_valid = 1'b0;
    cyc_end();
    rst = 1'b1;
    #1 chk("midrst_valid", {31'b0, vld[1]}, 32'd0);
    cyc_end();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("midrst_l3_valid%0d", k), {31'b0, vld[1]}, 32'd0);
      chk($sformatf("midrst_l2_valid%0d", k), {31'b0, vld[2]}, 32'd0);
      cyc_end();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, memory depth in 32-bit words (power of two, >= 4).
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have parameter LATENCY, default 0, extra wait cycles per fetch (0..7).
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-007 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-008 SHALL have port req_valid_i  input  1  fetch request valid.
REQ-009 SHALL have port req_ready_o  output  1  fetch request accepted when high with req_valid_i.
REQ-010 SHALL have port req_addr_i  input  ADDR_WIDTH  byte address of the instruction.
REQ-011 SHALL have port rsp_valid_o  output  1  response valid.
REQ-012 SHALL have port rsp_ready_i  input  1  consumer takes response.
REQ-013 SHALL have port rsp_inst_o  output  INST_WIDTH  fetched instruction.
REQ-014 SHALL have port rsp_err_o  output  1  fetch fault (misaligned or out of range).
REQ-015 SHALL have port flush_i  input  1  drop any outstanding fetch (redirect).
REQ-016 SHALL have port wr_en_i  input  1  program-load word write enable.
REQ-017 SHALL have port wr_addr_i  input  ADDR_WIDTH  byte address of load write.
REQ-018 SHALL have port wr_data_i  input  INST_WIDTH  load write data.
REQ-019 SHALL have port wr_be_i  input  INST_WIDTH/8  byte enables of load write.

Function
REQ-020 SHALL implement states IDLE, WAIT, RESP with one outstanding fetch maximum.
REQ-021 SHALL drive req_ready_o = 1 in IDLE, = rsp_ready_i in RESP, = 0 in WAIT, and = 0 whenever flush_i is high.
REQ-022 SHALL on accept read memory[req_addr_i >> 2] into the response register in the accept cycle (synchronous read).
REQ-023 SHALL go IDLE->RESP on accept when LATENCY=0, or IDLE->WAIT loading a down-counter with LATENCY when LATENCY>0.
REQ-024 SHALL leave WAIT for RESP on the cycle the counter reaches 1, making rsp_valid_o rise exactly LATENCY+1 cycles after accept.
REQ-025 SHALL hold rsp_valid_o, rsp_inst_o, rsp_err_o stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-026 SHALL in RESP with rsp_ready_i=1 return to IDLE, or restart per REQ-023 if a new request is accepted that cycle (1 fetch/cycle at LATENCY=0).
REQ-027 SHALL flag rsp_err_o=1 and return rsp_inst_o=32'h00000013 (NOP) when req_addr_i[1:0] != 0 or req_addr_i >= 4*MEM_SIZE; latency identical to a normal fetch.
REQ-028 SHALL on flush_i=1 go to IDLE next cycle from any state, deassert rsp_valid_o next cycle, and accept no request that cycle.
REQ-029 SHALL write wr_data_i bytes selected by wr_be_i into memory[wr_addr_i >> 2] when wr_en_i=1, independent of fetch state.
REQ-030 SHALL ignore writes with misaligned or out-of-range wr_addr_i.
REQ-031 SHALL return the old word when a fetch is accepted in the same cycle as a write to the same word (read-before-write).
REQ-032 SHALL never issue rsp_valid_o without a preceding accepted, unflushed request.

Reset
REQ-033 SHALL while rst_i=1 force state IDLE, counter 0, rsp_valid_o=0, rsp_inst_o=0, rsp_err_o=0, req_ready_o=0.
REQ-034 SHALL after rst_i deasserts drive req_ready_o=1 on the first clock edge; memory contents not reset.
REQ-035 SHALL abandon any in-flight fetch when reset asserts mid-operation, with no response after release.

Verification
REQ-036 SHALL cover: LATENCY=0, load 0x00500093 at 0x0, request 0x0 -> rsp_valid_o next cycle, rsp_inst_o=0x00500093, rsp_err_o=0.
REQ-037 SHALL cover: LATENCY=3, request 0x4 -> rsp_valid_o rises exactly 4 cycles after accept; req_ready_o=0 during WAIT.
REQ-038 SHALL cover: request 0x2 and request 0x1000 (MEM_SIZE=1024) -> rsp_err_o=1, rsp_inst_o=0x00000013 each.
REQ-039 SHALL cover: rsp_ready_i=0 for 5 cycles, then 1 with a new request 0x8 -> response held stable, 0x8 accepted on release cycle.
REQ-040 SHALL cover: LATENCY=2, flush_i pulse 1 cycle after accept -> no response, req_ready_o=1 on following cycle.
REQ-041 SHALL cover: write 0xDEADBEEF, wr_be_i=4'b0011 over 0x00000000 at 0xC, then fetch 0xC -> rsp_inst_o=0x0000BEEF.
